// File: rtl/scpad_tile_agen.sv
// scpad_tile_agen: per-tile beat sequencer producing skewed bank-parallel slot/shift/enable masks
module scpad_tile_agen #(
   parameter int SCPAD_SIZE_BYTES = 1048576,
   parameter int NUM_COLS         = 32,
   parameter int ELEM_BITS        = 16,
   parameter int MAX_TILE_SIZE    = 32,
   localparam int ROW_BYTES        = NUM_COLS * ELEM_BITS / 8,
   localparam int NUM_ROWS         = SCPAD_SIZE_BYTES / ROW_BYTES,
   localparam int ROW_SHIFT        = $clog2(ROW_BYTES),
   localparam int SCPAD_ADDR_WIDTH = $clog2(SCPAD_SIZE_BYTES),
   localparam int ROW_IDX_WIDTH    = $clog2(NUM_ROWS),
   localparam int COL_IDX_WIDTH    = $clog2(NUM_COLS),
   localparam int DIM_W            = $clog2(MAX_TILE_SIZE) + 1
) (
   input  logic                              CLK,
   input  logic                              nRST,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [SCPAD_ADDR_WIDTH-1:0]       req_base_addr,
   input  logic [DIM_W-1:0]                  req_rows,
   input  logic [DIM_W-1:0]                  req_cols,
   input  logic                              req_transpose,
   input  logic                              abort,
   output logic                              beat_valid,
   input  logic                              beat_ready,
   output logic [NUM_COLS*ROW_IDX_WIDTH-1:0] beat_slot_mask,
   output logic [NUM_COLS*COL_IDX_WIDTH-1:0] beat_shift_mask,
   output logic [NUM_COLS-1:0]               beat_en_mask,
   output logic [DIM_W-2:0]                  beat_idx,
   output logic                              beat_last,
   output logic                              busy,
   output logic                              done,
   output logic                              err
);
   localparam int RW1 = ROW_IDX_WIDTH + 1;
   localparam int LW  = COL_IDX_WIDTH + 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_d;
   logic [ROW_IDX_WIDTH-1:0] req_row, base_row_q, n_base_row;
   logic [DIM_W-1:0] rows_q, cols_q, k_q, n_rows, n_cols, n_k;
   logic tr_q, n_tr;
   logic [RW1-1:0] end_sum;
   logic legal, load, last, adv, n_last;
   logic [NUM_COLS*ROW_IDX_WIDTH-1:0] slot_d;
   logic [NUM_COLS*COL_IDX_WIDTH-1:0] shift_d;
   logic [NUM_COLS-1:0] en_d;
   assign req_row = req_base_addr[SCPAD_ADDR_WIDTH-1:ROW_SHIFT];
   // base_row + rows > NUM_ROWS means the tile would run past the last slot
   assign end_sum = {1'b0, req_row} + RW1'(req_rows);
   assign legal = (req_base_addr[ROW_SHIFT-1:0] == '0) && (req_rows != '0) && (req_cols != '0) &&
                  (req_rows <= DIM_W'(MAX_TILE_SIZE)) && (req_cols <= DIM_W'(MAX_TILE_SIZE)) &&
                  (end_sum <= RW1'(NUM_ROWS));
   assign load = (state == IDLE) && req_valid && legal;
   assign last = k_q == ((tr_q ? cols_q : rows_q) - DIM_W'(1));
   assign adv = (state == RUN) && beat_ready && !abort && !last;
   assign n_base_row = load ? req_row : base_row_q;
   assign n_rows = load ? req_rows : rows_q;
   assign n_cols = load ? req_cols : cols_q;
   assign n_tr = load ? req_transpose : tr_q;
   assign n_k = load ? '0 : adv ? k_q + DIM_W'(1) : k_q;
   assign n_last = n_k == ((n_tr ? n_cols : n_rows) - DIM_W'(1));
   // state register
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) state <= IDLE;
      else state <= state_d;
   // next state: abort beats the final handshake
   always_comb
      state_d = load ? RUN : ((state == RUN) && (abort || (beat_ready && last))) ? IDLE : state;
   // state-decoded outputs
   always_comb begin
      req_ready = state == IDLE;
      busy = state == RUN;
   end
   // masks for the beat that will be presented next cycle; bank b holds lane (b-k) mod NUM_COLS
   always_comb begin
      slot_d = '0;
      shift_d = '0;
      en_d = '0;
      for (int b = 0; b < NUM_COLS; b++) begin
         logic [COL_IDX_WIDTH-1:0] lane;
         lane = COL_IDX_WIDTH'(b) - n_k[COL_IDX_WIDTH-1:0];
         if (LW'(lane) < LW'(n_tr ? n_rows : n_cols)) begin
            en_d[b] = 1'b1;
            slot_d[b*ROW_IDX_WIDTH +: ROW_IDX_WIDTH] = n_base_row + (n_tr ? ROW_IDX_WIDTH'(lane) : ROW_IDX_WIDTH'(n_k));
            shift_d[b*COL_IDX_WIDTH +: COL_IDX_WIDTH] = lane;
         end
      end
   end
   // captured tile context and beat counter
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         base_row_q <= '0;
         rows_q <= '0;
         cols_q <= '0;
         tr_q <= 1'b0;
         k_q <= '0;
      end else begin
         base_row_q <= n_base_row;
         rows_q <= n_rows;
         cols_q <= n_cols;
         tr_q <= n_tr;
         k_q <= n_k;
      end
   // registered beat outputs and status pulses
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         beat_valid <= 1'b0;
         beat_slot_mask <= '0;
         beat_shift_mask <= '0;
         beat_en_mask <= '0;
         beat_idx <= '0;
         beat_last <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         beat_valid <= state_d == RUN;
         beat_slot_mask <= (state_d == RUN) ? slot_d : '0;
         beat_shift_mask <= (state_d == RUN) ? shift_d : '0;
         beat_en_mask <= (state_d == RUN) ? en_d : '0;
         beat_idx <= (state_d == RUN) ? n_k[DIM_W-2:0] : '0;
         beat_last <= (state_d == RUN) && n_last;
         done <= (state == RUN) && beat_ready && last && !abort;
         err <= (state == IDLE) && req_valid && !legal;
      end
endmodule

// File: tb/tb_scpad_tile_agen.sv
// tb_scpad_tile_agen: table, random and corner-sequence checks of scpad_tile_agen against an element-level model
module tb_scpad_tile_agen;
   localparam int NC = 32;
   localparam int RW = 14;
   localparam int CW = 5;
   localparam int DW = 6;
   localparam int AW = 20;
   localparam int NROWS = 16384;
   logic CLK = 1'b0, nRST = 1'b0;
   logic req_valid = 1'b0, req_transpose = 1'b0, abort = 1'b0, beat_ready = 1'b0;
   logic [AW-1:0] req_base_addr = '0;
   logic [DW-1:0] req_rows = '0, req_cols = '0;
   logic req_ready, beat_valid, beat_last, busy, done, err;
   logic [NC*RW-1:0] beat_slot_mask;
   logic [NC*CW-1:0] beat_shift_mask;
   logic [NC-1:0] beat_en_mask;
   logic [DW-2:0] beat_idx;
   int n_cmp = 0, n_bad = 0;
   typedef struct {int base; int rows; int cols; bit tr; bit exp_err;} vec_t;
   vec_t tbl[11];
   scpad_tile_agen dut (
      .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
      .req_base_addr(req_base_addr), .req_rows(req_rows), .req_cols(req_cols),
      .req_transpose(req_transpose), .abort(abort), .beat_valid(beat_valid),
      .beat_ready(beat_ready), .beat_slot_mask(beat_slot_mask), .beat_shift_mask(beat_shift_mask),
      .beat_en_mask(beat_en_mask), .beat_idx(beat_idx), .beat_last(beat_last),
      .busy(busy), .done(done), .err(err)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // each tile element (r,c) sits in bank (r+c)%NC at slot base_row+r; a beat is one tile row or column
   function automatic void model(input int br, input int rows, input int cols, input bit tr, input int k,
                                 output logic [NC*RW-1:0] s, output logic [NC*CW-1:0] h, output logic [NC-1:0] e);
      s = '0;
      h = '0;
      e = '0;
      if (!tr) for (int c = 0; c < cols; c++) begin
         int b = (k + c) % NC;
         e[b] = 1'b1;
         s[b*RW +: RW] = RW'(br + k);
         h[b*CW +: CW] = CW'(c);
      end else for (int r = 0; r < rows; r++) begin
         int b = (k + r) % NC;
         e[b] = 1'b1;
         s[b*RW +: RW] = RW'(br + r);
         h[b*CW +: CW] = CW'(r);
      end
   endfunction
   function automatic bit is_illegal(input int base, input int rows, input int cols);
      return (base % 64 != 0) || rows < 1 || rows > 32 || cols < 1 || cols > 32 || (base / 64 + rows - 1 >= NROWS);
   endfunction
   task automatic check_beat(input int base, input int rows, input int cols, input bit tr, input int k);
      logic [NC*RW-1:0] s;
      logic [NC*CW-1:0] h;
      logic [NC-1:0] e;
      int n = tr ? cols : rows;
      model(base / 64, rows, cols, tr, k, s, h, e);
      chk("beat_valid", beat_valid, 1);
      chk("beat_idx", beat_idx, k);
      chk("beat_last", beat_last, k == n - 1);
      chk("slot_mask", beat_slot_mask, s);
      chk("shift_mask", beat_shift_mask, h);
      chk("en_mask", beat_en_mask, e);
      chk("busy_run", busy, 1);
      chk("req_ready_run", req_ready, 0);
      chk("done_run", done, 0);
   endtask
   task automatic send_req(input int base, input int rows, input int cols, input bit tr);
      req_valid = 1'b1;
      req_base_addr = base[AW-1:0];
      req_rows = rows[DW-1:0];
      req_cols = cols[DW-1:0];
      req_transpose = tr;
      @(negedge CLK);
      req_valid = 1'b0;
   endtask
   task automatic check_idle_after_done();
      chk("done_pulse", done, 1);
      chk("beat_valid_end", beat_valid, 0);
      chk("req_ready_end", req_ready, 1);
      chk("busy_end", busy, 0);
      @(negedge CLK);
      chk("done_clear", done, 0);
   endtask
   task automatic run_tile(input int base, input int rows, input int cols, input bit tr, input bit exp_err, input bit stall);
      int n = tr ? cols : rows;
      int k = 0;
      int guard = 0;
      bit rdy;
      send_req(base, rows, cols, tr);
      if (exp_err) begin
         chk("err_pulse", err, 1);
         chk("err_no_beat", beat_valid, 0);
         chk("err_req_ready", req_ready, 1);
         chk("err_busy", busy, 0);
         @(negedge CLK);
         chk("err_clear", err, 0);
         chk("err_no_beat2", beat_valid, 0);
      end else begin
         while (k < n) begin
            check_beat(base, rows, cols, tr, k);
            rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            beat_ready = rdy;
            @(negedge CLK);
            if (rdy) k++;
            guard++;
            if (guard > 2000) begin
               chk("beat_timeout", guard, 0);
               break;
            end
         end
         beat_ready = 1'b0;
         check_idle_after_done();
      end
   endtask
   initial begin
      tbl[0]  = '{0, 4, 32, 1'b0, 1'b0};
      tbl[1]  = '{'h400, 3, 2, 1'b1, 1'b0};
      tbl[2]  = '{'h401, 4, 4, 1'b0, 1'b1};
      tbl[3]  = '{0, 33, 4, 1'b0, 1'b1};
      tbl[4]  = '{0, 4, 0, 1'b1, 1'b1};
      tbl[5]  = '{(NROWS - 2) * 64, 3, 4, 1'b0, 1'b1};
      tbl[6]  = '{(NROWS - 2) * 64, 2, 4, 1'b0, 1'b0};
      tbl[7]  = '{'h40, 1, 1, 1'b0, 1'b0};
      tbl[8]  = '{'h80, 32, 32, 1'b1, 1'b0};
      tbl[9]  = '{'h1000, 0, 5, 1'b1, 1'b1};
      tbl[10] = '{0, 4, 33, 1'b1, 1'b1};
      @(negedge CLK);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_beat_valid", beat_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_en", beat_en_mask, 0);
      chk("rst_slot", beat_slot_mask, 0);
      nRST = 1'b1;
      @(negedge CLK);
      for (int i = 0; i < 11; i++) run_tile(tbl[i].base, tbl[i].rows, tbl[i].cols, tbl[i].tr, tbl[i].exp_err, 1'b0);
      // stall on beat 1 for five cycles
      send_req(0, 4, 8, 1'b0);
      check_beat(0, 4, 8, 1'b0, 0);
      beat_ready = 1'b1;
      @(negedge CLK);
      beat_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_beat(0, 4, 8, 1'b0, 1);
         @(negedge CLK);
      end
      beat_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         check_beat(0, 4, 8, 1'b0, k);
         @(negedge CLK);
      end
      beat_ready = 1'b0;
      check_idle_after_done();
      // abort during beat 2 of 8
      send_req(0, 8, 8, 1'b0);
      beat_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         check_beat(0, 8, 8, 1'b0, k);
         @(negedge CLK);
      end
      beat_ready = 1'b0;
      check_beat(0, 8, 8, 1'b0, 2);
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      chk("abort_valid", beat_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", req_ready, 1);
      chk("abort_done", done, 0);
      @(negedge CLK);
      chk("abort_done2", done, 0);
      // abort coinciding with the final handshake suppresses done
      send_req('h40, 1, 1, 1'b0);
      check_beat('h40, 1, 1, 1'b0, 0);
      beat_ready = 1'b1;
      abort = 1'b1;
      @(negedge CLK);
      beat_ready = 1'b0;
      abort = 1'b0;
      chk("abort_last_done", done, 0);
      chk("abort_last_valid", beat_valid, 0);
      chk("abort_last_ready", req_ready, 1);
      // abort while idle is ignored
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      chk("idle_abort_ready", req_ready, 1);
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_err", err, 0);
      run_tile('h2000, 2, 3, 1'b1, 1'b0, 1'b0);
      // asynchronous reset mid-tile
      send_req(0, 8, 8, 1'b1);
      beat_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check_beat(0, 8, 8, 1'b1, k);
         @(negedge CLK);
      end
      beat_ready = 1'b0;
      check_beat(0, 8, 8, 1'b1, 3);
      nRST = 1'b0;
      #1;
      chk("mrst_valid", beat_valid, 0);
      chk("mrst_slot", beat_slot_mask, 0);
      chk("mrst_shift", beat_shift_mask, 0);
      chk("mrst_en", beat_en_mask, 0);
      chk("mrst_idx", beat_idx, 0);
      chk("mrst_last", beat_last, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ready", req_ready, 1);
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      chk("mrst_after_valid", beat_valid, 0);
      chk("mrst_after_ready", req_ready, 1);
      run_tile(0, 8, 8, 1'b1, 1'b0, 1'b0);
      // randomized tiles with random backpressure
      for (int i = 0; i < 40; i++) begin
         int base, rows, cols;
         bit tr;
         base = $urandom_range(0, NROWS - 1) * 64;
         if ($urandom_range(0, 7) == 0) base += $urandom_range(1, 63);
         rows = $urandom_range(0, 12) == 0 ? $urandom_range(0, 1) * 33 : $urandom_range(1, 32);
         cols = $urandom_range(0, 12) == 0 ? $urandom_range(0, 1) * 33 : $urandom_range(1, 32);
         tr = 1'($urandom_range(0, 1));
         run_tile(base, rows, cols, tr, is_illegal(base, rows, cols), 1'b1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
